matrix_keypad_scanner: RTL and testbench

Parametrised ROWS×COLS matrix keypad scanner with per-column dwell, multi-sample debounce, press/release event generation and a small event FIFO drained through a valid/ready handshake. Sits between the keypad pins and the calculator input decoder, replacing the fixed 4×4 scanner. It emits linear key codes; mapping codes to digits and operators stays in the decoder.

---
 rtl/matrix_keypad_scanner.sv | 138 +++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_keypad_scanner.sv
// matrix_keypad_scanner: debounced ROWSxCOLS keypad scanner with press/release event FIFO (clk, reset, row in; col, ev_valid/ev_code/ev_release out with ev_ready; pressed, held_code, overflow status)
module matrix_keypad_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CW-1:0]   ev_code,
  output logic            ev_release,
  output logic            pressed,
  output logic [CW-1:0]   held_code,
  output logic            overflow
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int KW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int NW = $clog2(DEBOUNCE+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;
  state_t r_state, w_state;
  logic [DW-1:0] r_dwell;
  logic [KW-1:0] r_col_idx, w_col_idx, w_col_adv;
  logic [RW-1:0] r_row_idx, w_row_idx, w_low_row;
  logic [NW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [COLS-1:0] r_col;
  logic r_pressed, r_overflow;
  logic [CW-1:0] r_held_code, w_push_code;
  logic w_sample, w_confirm, w_push, w_push_rel, w_pop, w_full, w_wr;
  logic [CW:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_count;
  assign w_sample = r_dwell == DW'(SCAN_DIV-1);
  assign w_col_adv = r_col_idx == KW'(COLS-1) ? '0 : r_col_idx + 1'b1;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_confirm = w_cnt_inc == NW'(DEBOUNCE);
  assign w_push_code = CW'(w_row_idx) * CW'(COLS) + CW'(r_col_idx);
  assign w_pop = ev_valid && ev_ready;
  assign w_full = r_count == (PW+1)'(FIFO_DEPTH);
  assign w_wr = w_push && (!w_full || w_pop);
  assign col = r_col;
  assign pressed = r_pressed;
  assign held_code = r_held_code;
  assign overflow = r_overflow;
  assign ev_valid = r_count != '0;
  assign ev_code = ev_valid ? r_mem[r_rp][CW-1:0] : '0;
  assign ev_release = ev_valid && r_mem[r_rp][CW];
  always_comb begin
    w_low_row = '0;
    for (int i = ROWS-1; i >= 0; i--)
      if (!row[i]) w_low_row = RW'(i);
  end
  always_comb begin
    w_state = r_state;
    w_col_idx = r_col_idx;
    w_row_idx = r_row_idx;
    w_cnt = r_cnt;
    w_push = 1'b0;
    w_push_rel = 1'b0;
    if (w_sample)
      case (r_state)
        SCAN:
          if (&row) w_col_idx = w_col_adv;
          else begin
            w_row_idx = w_low_row;
            w_cnt = NW'(1);
            w_push = DEBOUNCE == 1;
            w_state = DEBOUNCE == 1 ? HELD : DEB_PRESS;
          end
        DEB_PRESS:
          if (row[r_row_idx]) begin
            w_state = SCAN;
            w_col_idx = w_col_adv;
          end else begin
            w_cnt = w_cnt_inc;
            w_push = w_confirm;
            w_state = w_confirm ? HELD : DEB_PRESS;
          end
        HELD:
          if (row[r_row_idx]) begin
            w_cnt = NW'(1);
            w_push = DEBOUNCE == 1;
            w_push_rel = 1'b1;
            w_state = DEBOUNCE == 1 ? SCAN : DEB_REL;
            w_col_idx = DEBOUNCE == 1 ? w_col_adv : r_col_idx;
          end
        DEB_REL:
          if (row[r_row_idx]) begin
            w_cnt = w_cnt_inc;
            w_push = w_confirm;
            w_push_rel = 1'b1;
            w_state = w_confirm ? SCAN : DEB_REL;
            w_col_idx = w_confirm ? w_col_adv : r_col_idx;
          end else w_state = HELD;
        default: w_state = SCAN;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCAN;
      r_dwell <= '0;
      r_col_idx <= '0;
      r_row_idx <= '0;
      r_cnt <= '0;
      r_col <= ~COLS'(1);
      r_pressed <= 1'b0;
      r_held_code <= '0;
      r_overflow <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state;
      r_dwell <= w_sample ? '0 : r_dwell + 1'b1;
      r_col_idx <= w_col_idx;
      r_row_idx <= w_row_idx;
      r_cnt <= w_cnt;
      r_col <= ~(COLS'(1) << w_col_idx);
      if (w_push) begin
        r_pressed <= !w_push_rel;
        r_held_code <= w_push_rel ? '0 : w_push_code;
      end
      if (w_push && !w_wr) r_overflow <= 1'b1;
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, w_pop};
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= {w_push_rel, w_push_code};
endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// tb_matrix_keypad_scanner: scoreboard bench for the keypad scanner with a key-matrix model driving the rows
module tb_matrix_keypad_scanner;
  logic clk = 1'b0, reset = 1'b1, ev_ready = 1'b1;
  logic ev_valid, ev_release, pressed, overflow;
  logic [3:0] row, col, ev_code, held_code;
  logic [15:0] keys = '0;
  logic [4:0] exp_q[$];
  logic exp_ovf = 1'b0;
  int cyc = 0, n_vec = 0, n_fail = 0;
  int a, b, c, d, e;
  always #5 clk = ~clk;
  matrix_keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_release(ev_release), .pressed(pressed), .held_code(held_code), .overflow(overflow));
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (keys[r*4+k] && col[k] == 1'b0) row[r] = 1'b0;
  end
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_event: actual=%0h required=none", {ev_release, ev_code});
      end else chk("event", {27'd0, ev_release, ev_code}, {27'd0, exp_q.pop_front()});
    end
  task automatic expect_ev(input int code, input logic rel, input logic will_pop);
    if (exp_q.size() < 4 || will_pop) exp_q.push_back({rel, 4'(code)});
    else exp_ovf = 1'b1;
  endtask
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask
  task automatic at_cyc(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc < k && n < 1000);
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk); #1 ev_ready = v;
  endtask
  task automatic wait_pressed(input logic v);
    int n = 0;
    while (pressed !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("pressed_wait", pressed, v);
  endtask
  task automatic press_key(input int code);
    expect_ev(code, 1'b0, 1'b0);
    keys[code] = 1'b1;
    wait_pressed(1'b1);
    chk("held_code", held_code, code);
  endtask
  task automatic release_key(input int code);
    expect_ev(code, 1'b1, 1'b0);
    keys[code] = 1'b0;
    wait_pressed(1'b0);
    chk("held_code_clear", held_code, 0);
  endtask
  task automatic release_timed(input int code);
    int sc;
    @(posedge clk); #1 keys[code] = 1'b0;
    sc = cyc + (3 - cyc % 4) + 8;
    while (cyc < sc) begin
      @(posedge clk);
      #1;
    end
    ev_ready = 1'b1;
    expect_ev(code, 1'b1, 1'b1);
    @(posedge clk); #1 ev_ready = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    for (int k = 0; k < 20; k++) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << ((k / 4) % 4));
      at_cyc(k);
      chk("idle_col", col, ec);
      chk("idle_valid", ev_valid, 0);
    end
    chk("rst_overflow", overflow, 0);
    do_reset();
    expect_ev(9, 1'b0, 1'b0);
    keys[9] = 1'b1;
    at_cyc(15);
    chk("press_early_valid", ev_valid, 0);
    chk("press_early_pressed", pressed, 0);
    at_cyc(16);
    chk("press_valid", ev_valid, 1);
    chk("press_code", ev_code, 9);
    chk("press_rel", ev_release, 0);
    chk("press_pressed", pressed, 1);
    chk("press_held", held_code, 9);
    at_cyc(17);
    expect_ev(9, 1'b1, 1'b0);
    keys[9] = 1'b0;
    at_cyc(28);
    chk("rel_valid", ev_valid, 1);
    chk("rel_code", ev_code, 9);
    chk("rel_rel", ev_release, 1);
    chk("rel_pressed", pressed, 0);
    chk("rel_held", held_code, 0);
    chk("rel_col", col, 4'b1011);
    keys[6] = 1'b1;
    at_cyc(36);
    chk("bounce_hold_col", col, 4'b1011);
    keys[6] = 1'b0;
    at_cyc(40);
    chk("bounce_col", col, 4'b0111);
    chk("bounce_pressed", pressed, 0);
    chk("bounce_valid", ev_valid, 0);
    at_cyc(44);
    chk("bounce_wrap_col", col, 4'b1110);
    for (int i = 0; i < 6; i++) begin
      int code;
      code = $urandom_range(0, 15);
      repeat ($urandom_range(0, 9)) @(negedge clk);
      press_key(code);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      release_key(code);
    end
    repeat (4) @(negedge clk);
    chk("rand_drained", exp_q.size(), 0);
    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    c = $urandom_range(0, 15);
    set_ready(1'b0);
    press_key(a);
    release_key(a);
    press_key(b);
    release_key(b);
    press_key(c);
    chk("ovf_flag", overflow, exp_ovf);
    chk("ovf_valid", ev_valid, 1);
    chk("ovf_head_code", ev_code, a);
    chk("ovf_head_rel", ev_release, 0);
    release_timed(c);
    @(negedge clk);
    chk("full_pp_pressed", pressed, 0);
    chk("full_pp_valid", ev_valid, 1);
    chk("full_pp_head_code", ev_code, a);
    chk("full_pp_head_rel", ev_release, 1);
    set_ready(1'b1);
    repeat (8) @(negedge clk);
    chk("full_drained", exp_q.size(), 0);
    chk("full_empty_valid", ev_valid, 0);
    chk("ovf_sticky", overflow, exp_ovf);
    d = $urandom_range(0, 15);
    e = $urandom_range(0, 15);
    set_ready(1'b0);
    press_key(d);
    release_key(d);
    press_key(e);
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    chk("pre_rst_valid", ev_valid, 1);
    chk("pre_rst_pressed", pressed, 1);
    @(posedge clk); #1 reset = 1'b1;
    keys = '0;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_pressed", pressed, 0);
    chk("mid_rst_col", col, 4'b1110);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_held", held_code, 0);
    set_ready(1'b1);
    repeat (40) @(negedge clk);
    chk("post_rst_quiet", ev_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
